// File: rtl/wb_timer.sv
// ============================================================================
// Module   : wb_timer
// Purpose  : Wishbone machine timer with a 64-bit mtime, a 64-bit mtimecmp
//            and a prescaler, driving a level timer interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timer #(
  parameter int                    PRESCALE_W   = 16,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        timer_int_o
);

  localparam logic [2:0] ADR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADR_CTRL     = 3'd4;
  localparam logic [2:0] ADR_PRESCALE = 3'd5;
  localparam logic [2:0] ADR_STATUS   = 3'd6;

  logic [63:0]           mtime_q,     mtime_d;
  logic [31:0]           shadow_hi_q, shadow_hi_d;
  logic [63:0]           cmp_q,       cmp_d;
  logic                  en_q,        en_d;
  logic                  ie_q,        ie_d;
  logic [PRESCALE_W-1:0] presc_q,     presc_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic                  ack_q,       ack_d;
  logic [31:0]           dat_q,       dat_d;
  logic                  int_q,       int_d;

  logic        access;
  logic        wr;
  logic        rd;
  logic        tick;
  logic        match;
  logic [63:0] mtime_inc;
  logic [31:0] rdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  assign access    = wb_stb_i & ~ack_q;
  assign wr        = access & wb_we_i;
  assign rd        = access & ~wb_we_i;
  assign tick      = en_q && (presc_cnt_q == presc_q);
  assign match     = (mtime_q >= cmp_q);
  assign mtime_inc = mtime_q + 64'd1;

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      ADR_MTIME_LO: rdata = mtime_q[31:0];
      ADR_MTIME_HI: rdata = shadow_hi_q;
      ADR_CMP_LO:   rdata = cmp_q[31:0];
      ADR_CMP_HI:   rdata = cmp_q[63:32];
      ADR_CTRL:     rdata = {30'd0, ie_q, en_q};
      ADR_PRESCALE: rdata[PRESCALE_W-1:0] = presc_q;
      ADR_STATUS:   rdata = {31'd0, match};
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    mtime_d     = tick ? mtime_inc : mtime_q;
    shadow_hi_d = shadow_hi_q;
    cmp_d       = cmp_q;
    en_d        = en_q;
    ie_d        = ie_q;
    presc_d     = presc_q;
    presc_cnt_d = presc_cnt_q + 1'b1;
    if (!en_q || tick) presc_cnt_d = '0;

    // A bus write to either mtime half suppresses the tick for the whole word.
    if (wr) begin
      case (wb_adr_i)
        ADR_MTIME_LO: mtime_d = {mtime_q[63:32],
                                 merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
        ADR_MTIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i),
                                 mtime_q[31:0]};
        ADR_CMP_LO:   cmp_d[31:0]  = merge_bytes(cmp_q[31:0], wb_dat_i, wb_sel_i);
        ADR_CMP_HI:   cmp_d[63:32] = merge_bytes(cmp_q[63:32], wb_dat_i, wb_sel_i);
        ADR_CTRL: begin
          if (wb_sel_i[0]) begin
            en_d = wb_dat_i[0];
            ie_d = wb_dat_i[1];
          end
        end
        ADR_PRESCALE: begin
          for (int i = 0; i < PRESCALE_W; i++) begin
            if (wb_sel_i[i/8]) presc_d[i] = wb_dat_i[i];
          end
          presc_cnt_d = '0;
        end
        default: ;
      endcase
    end

    if (rd && (wb_adr_i == ADR_MTIME_LO)) shadow_hi_d = mtime_q[63:32];

    ack_d = wb_stb_i & ~ack_q;
    dat_d = access ? rdata : dat_q;
    int_d = match & ie_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mtime_q     <= '0;
      shadow_hi_q <= '0;
      cmp_q       <= '1;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      presc_q     <= PRESCALE_RST;
      presc_cnt_q <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      int_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      shadow_hi_q <= shadow_hi_d;
      cmp_q       <= cmp_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      int_q       <= int_d;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign timer_int_o = int_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_timer.sv
// ============================================================================
// Module   : tb_wb_timer
// Purpose  : Directed scoreboard bench for wb_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_timer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        ack;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_data_q[$];
  bit          exp_chk_q[$];
  string       exp_name_q[$];

  wb_timer dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wb_adr_i    (adr),
    .wb_dat_i    (wdat),
    .wb_dat_o    (rdat),
    .wb_we_i     (we),
    .wb_sel_i    (sel),
    .wb_stb_i    (stb),
    .wb_ack_o    (ack),
    .timer_int_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard monitor: every ack consumes one expected entry
  always @(posedge clk) begin
    #1;
    if (ack === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        bit          c;
        string       nm;
        e  = exp_data_q.pop_front();
        c  = exp_chk_q.pop_front();
        nm = exp_name_q.pop_front();
        if (c) check(nm, rdat, e);
      end
    end
  end

  task automatic xfer(input bit w, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit c, input logic [31:0] e,
                      input string nm);
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    exp_data_q.push_back(e);
    exp_chk_q.push_back(c);
    exp_name_q.push_back(nm);
    @(posedge clk); #1;
    check({nm, "_ack_rise"}, {31'd0, ack}, 32'd1);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({nm, "_ack_fall"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 4'hF, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    xfer(1'b0, a, 32'd0, 4'hF, 1'b1, e, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_int", {31'd0, irq}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values of all eight words
    rd(3'd0, 32'd0,        "rst_mtime_lo");
    rd(3'd1, 32'd0,        "rst_mtime_hi");
    rd(3'd2, 32'hFFFFFFFF, "rst_cmp_lo");
    rd(3'd3, 32'hFFFFFFFF, "rst_cmp_hi");
    rd(3'd4, 32'd0,        "rst_ctrl");
    rd(3'd5, 32'd0,        "rst_prescale");
    rd(3'd6, 32'd0,        "rst_status");
    rd(3'd7, 32'd0,        "rst_word7");

    // Prescale by 4: one tick per four enabled clocks
    wr(3'd5, 32'd3);
    rd(3'd5, 32'd3, "prescale_rb");
    wr(3'd4, 32'd1);
    repeat (40) @(posedge clk);
    rd(3'd0, 32'd10, "presc_count");
    wr(3'd4, 32'd0);
    repeat (20) @(posedge clk);
    rd(3'd0, 32'd11, "frozen_count");

    // 64-bit wrap and atomic shadow read
    wr(3'd5, 32'd0);
    wr(3'd0, 32'hFFFFFFFE);
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd1);
    repeat (4) @(posedge clk);
    rd(3'd0, 32'h00000003, "wrap_lo");
    rd(3'd1, 32'h00000001, "wrap_hi_shadow");

    // Interrupt timing
    wr(3'd4, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd90);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd100);
    wr(3'd4, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("int_before_match", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("int_after_match", {31'd0, irq}, 32'd1);
    wr(3'd2, 32'd1000);
    check("int_clear_cmp", {31'd0, irq}, 32'd0);
    wr(3'd4, 32'd1);
    wr(3'd2, 32'd50);
    rd(3'd6, 32'd1, "status_no_ie");
    check("int_masked", {31'd0, irq}, 32'd0);
    rd(3'd4, 32'd1, "ctrl_rb");

    // Byte lanes and write-during-tick
    wr(3'd2, 32'hFFFFFFFF);
    xfer(1'b1, 3'd2, 32'hAABBCCDD, 4'b0010, 1'b0, 32'd0, "wr_sel");
    rd(3'd2, 32'hFFFFCCFF, "cmp_lo_sel");
    wr(3'd0, 32'h12340000);
    rd(3'd0, 32'h12340001, "write_beats_tick");

    // Reset during an acknowledged transaction with the interrupt live
    wr(3'd4, 32'd3);
    wr(3'd2, 32'h10);
    repeat (2) @(posedge clk);
    #1;
    check("int_pre_reset", {31'd0, irq}, 32'd1);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 3'd6; sel = 4'hF;
    exp_data_q.push_back(32'd0);
    exp_chk_q.push_back(1'b0);
    exp_name_q.push_back("rst_mid_rd");
    @(posedge clk); #1;
    check("ack_pre_reset", {31'd0, ack}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", {31'd0, ack}, 32'd0);
    check("async_rst_int", {31'd0, irq}, 32'd0);
    check("async_rst_dat", rdat, 32'd0);
    stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd0, 32'd0,        "post_rst_mtime_lo");
    rd(3'd1, 32'd0,        "post_rst_mtime_hi");
    rd(3'd2, 32'hFFFFFFFF, "post_rst_cmp_lo");
    rd(3'd4, 32'd0,        "post_rst_ctrl");
    rd(3'd6, 32'd0,        "post_rst_status");

    repeat (2) @(posedge clk);
    #2;
    check("sb_drain", exp_data_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
